mem_controller: RTL
===================

Name: mem_controller

Overview:
- Memory-side stage directly downstream of the multi-cycle control unit.
- Consumes the Read / write_mem strobes, the MAR address and the MDR write data.
- Owns the 32-bit word RAM and returns read data to the MDR input mux.
- Asserts busy for a programmable number of wait states; the top level routes busy into the control unit's stop input, so the FSM freezes until the access completes.

Parameters:
- ADDR_WIDTH, 9, width of the word address taken from MAR[ADDR_WIDTH-1:0]
- DEPTH, 512, number of 32-bit words in the RAM (must be <= 2**ADDR_WIDTH)
- WAIT_STATES, 2, cycles busy is held per access (legal range 1..15)

Ports:
- clk  in  1  system clock, all state changes on posedge
- reset  in  1  asynchronous, active-high; clears all control state
- Read  in  1  read request level from the control unit
- write_mem  in  1  write request level from the control unit
- address  in  ADDR_WIDTH  word address from MAR
- data_in  in  32  write data from MDR
- data_out  out  32  registered read data to the MDR input mux
- busy  out  1  access in progress; drives control unit stop
- done  out  1  one-cycle pulse on access completion
- err  out  1  sticky error flag

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, data_out=0, err=0, rd_q=0, wr_q=0, wait counter=0. RAM contents are not cleared. An in-flight write is aborted and memory is unchanged.
- Edge detection: rd_q/wr_q register Read/write_mem every cycle, in all states. A request is level high with the _q copy low. A held level never retriggers, because the control unit holds Read across fetch1..load0.
- States: IDLE, RD_WAIT, WR_WAIT, DONE_ST.
- IDLE or DONE_ST, write edge detected at edge N:
  - latch address and data_in; cnt=WAIT_STATES-1; busy=1; go WR_WAIT.
- IDLE or DONE_ST, read edge only at edge N:
  - latch address; cnt=WAIT_STATES-1; busy=1; go RD_WAIT.
- Read and write edges on the same cycle: write wins, err<=1, read is dropped.
- RD_WAIT / WR_WAIT: cnt decrements each cycle. When cnt==0, the access executes on that edge (edge N+WAIT_STATES):
  - RD_WAIT: data_out<=mem[addr_l].
  - WR_WAIT: mem[addr_l]<=data_l.
  - Then go DONE_ST; busy<=0, done<=1.
- busy is therefore high for exactly WAIT_STATES cycles. With WAIT_STATES=1 it is high one cycle.
- DONE_ST: done is high for this single cycle. If no new edge arrives, go IDLE and done<=0. A new edge in DONE_ST is accepted as in IDLE, giving back-to-back accesses with one non-busy cycle between them.
- Edges while in RD_WAIT / WR_WAIT are ignored and not queued. err is not set for these.
- Out-of-range access (addr_l >= DEPTH): no RAM access; a read returns 32'h0 in data_out; err<=1. Timing is identical to a legal access.
- data_out holds its value between reads; writes never change data_out.
- err clears only on reset.

Test Plan:
- Reset mid-write: write edge at addr 5, data 32'hDEADBEEF, then reset asserted while in WR_WAIT, then read addr 5 -> returns the prior contents (preloaded 32'h0); busy=0 and data_out=0 immediately on reset.
- Write then read, WAIT_STATES=2: write 32'h12345678 to addr 9 -> busy high 2 cycles, done pulses 1 cycle. Then read addr 9 -> data_out=32'h12345678 on the same edge busy falls.
- Held Read level: Read held high for 6 cycles -> exactly one access, one done pulse, busy high 2 cycles only.
- Simultaneous Read and write_mem rising with data 32'hA5A5A5A5 at addr 3 -> write performed, err=1 sticky, no read. A later read of addr 3 -> 32'hA5A5A5A5.
- Out of range, DEPTH=256, ADDR_WIDTH=9: write to addr 300 then read addr 300 -> data_out=0, err=1, busy timing unchanged.
- Back-to-back: second read edge arriving in DONE_ST -> accepted, busy re-asserts next cycle. An edge arriving during RD_WAIT -> ignored, only one done pulse.

Source files
------------

// File: rtl/mem_controller.sv
`default_nettype none
// ============================================================================
// Module      : mem_controller
// Description : Memory-side stage behind the multi-cycle control unit. Owns a
//               32-bit word RAM and performs one read or write per rising
//               edge of Read / write_mem. It holds busy for WAIT_STATES
//               cycles, pulses done when the access completes, and keeps a
//               sticky err flag.
// Ports       : clk        - system clock, all state changes on posedge
//               reset      - asynchronous active-high; clears control state
//               Read       - read request level from the control unit
//               write_mem  - write request level from the control unit
//               address    - word address from MAR
//               data_in    - write data from MDR
//               data_out   - registered read data to the MDR input mux
//               busy       - access in progress (drives control unit stop)
//               done       - one-cycle pulse on access completion
//               err        - sticky error flag
// Revision    : 1.0 - initial release
// ============================================================================
module mem_controller #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DEPTH       = 512,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Read,
    input  logic                  write_mem,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           data_in,
    output logic [31:0]           data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int                  c_IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] c_DEPTH    = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [3:0]          c_CNT_INIT = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        DONE_ST = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    rd_q, wr_q;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             data_out_q, data_out_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic                    w_rd_edge;
    logic                    w_wr_edge;
    logic                    w_in_range;
    logic                    w_mem_we;
    logic [c_IDX_W-1:0]      w_idx;
    logic [31:0]             w_rdata;

    logic [31:0]             mem [DEPTH];

    // A request is a rising level; a level held across many cycles only
    // triggers once because rd_q / wr_q follow it every cycle.
    assign w_rd_edge  = Read & ~rd_q;
    assign w_wr_edge  = write_mem & ~wr_q;
    assign w_in_range = ({1'b0, addr_q} < c_DEPTH);
    assign w_idx      = addr_q[c_IDX_W-1:0];
    assign w_rdata    = mem[w_idx];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_out_d = data_out_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        w_mem_we   = 1'b0;

        case (state_q)
            IDLE, DONE_ST: begin
                state_d = IDLE;
                done_d  = 1'b0;
                if (w_wr_edge) begin
                    // Write wins a tie; the dropped read is flagged.
                    addr_d  = address;
                    wdata_d = data_in;
                    cnt_d   = c_CNT_INIT;
                    busy_d  = 1'b1;
                    state_d = WR_WAIT;
                    if (w_rd_edge) begin
                        err_d = 1'b1;
                    end
                end else if (w_rd_edge) begin
                    addr_d  = address;
                    cnt_d   = c_CNT_INIT;
                    busy_d  = 1'b1;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT, WR_WAIT: begin
                // New edges are ignored while waiting.
                if (cnt_q == 4'd0) begin
                    state_d = DONE_ST;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (!w_in_range) begin
                        err_d = 1'b1;
                    end
                    if (state_q == RD_WAIT) begin
                        data_out_d = w_in_range ? w_rdata : 32'h0;
                    end else begin
                        w_mem_we = w_in_range;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            data_out_q <= 32'h0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= Read;
            wr_q       <= write_mem;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // RAM contents survive reset. A write in flight is aborted because the
    // asynchronous reset pulls state_q out of WR_WAIT before its final edge.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem[w_idx] <= wdata_q;
        end
    end

    assign data_out = data_out_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
`default_nettype wire
